vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator: samples HS/VS sync pulses in the pixel clock domain and measures line period, sync widths and lines per frame. It locks onto a stable mode and regenerates pixel position and data-enable for the active window. It sits behind a loopback or capture path and checks generator output in-system.

---
 rtl/vga_sync_decoder.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing checker. It samples active-low HS/VS pulses once
// per pixel clock and measures the line period, the HS width, the lines per
// frame and the VS width. It locks onto a stable mode after a measure frame
// and a verify frame. While locked it regenerates the active-window pixel
// position (x/y) and data-enable.
//
// Optional feature macro: VGA_DECODE_STATS_EN
//   defined   -> frameCount counts frame starts seen while locked
//   undefined -> frameCount is tied to zero
//
// Ports
//   clk        pixel clock, one HS/VS sample per cycle
//   reset_     asynchronous active-low reset
//   hs, vs     sync inputs, active-low pulses, synchronous to clk
//   locked     mode verified; de/x/y are meaningful
//   de         active pixel (registered, one clock after the sample)
//   x, y       active column/row; x is 0 when de=0, y is 0 outside active lines
//   hPeriod    measured clocks per line
//   hSyncW     measured HS low width in clocks
//   vLines     measured lines per frame
//   vSyncW     measured VS low width in lines
//   err        one-cycle pulse when lock is lost
//   frameCount locked frame counter (see macro above)
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int HB   = 64,
    parameter int HC   = 800,
    parameter int VB   = 23,
    parameter int VC   = 600,
    parameter int VWIN = 8
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        hs,
    input  logic        vs,
    output logic        locked,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [10:0] hPeriod,
    output logic [10:0] hSyncW,
    output logic [9:0]  vLines,
    output logic [9:0]  vSyncW,
    output logic        err,
    output logic [15:0] frameCount
);

    localparam logic [10:0] HMAX = 11'h7FF;
    localparam logic [9:0]  LMAX = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic        pend_q, pend_d;
    logic [9:0]  vsw_q, vsw_d;
    logic        hp_got_q, hp_got_d;
    logic        hw_got_q, hw_got_d;
    logic [10:0] hper_q, hper_d;
    logic [10:0] hsw_q, hsw_d;
    logic [9:0]  vlin_q, vlin_d;
    logic [9:0]  vsyw_q, vsyw_d;
    logic        de_q, de_d;
    logic        err_q, err_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        fstart, hsat, mis;
    logic [10:0] k, h_period;
    logic [9:0]  lnext, frame_lines;
    logic [11:0] h_lo, h_hi;
    logic [10:0] v_lo, v_hi;
    logic        h_in, v_in;

    // -----------------------------------------------------------------------
    // Edge detection and line/frame counters.
    // hcnt_d (= k) is the index of the sample being taken this cycle, so
    // hcnt_q is the index of the previous sample; lcnt_d is the current line L.
    // -----------------------------------------------------------------------
    always_comb begin
        hs_fall = hs_q & ~hs;
        hs_rise = ~hs_q & hs;
        vs_fall = vs_q & ~vs;
        vs_rise = ~vs_q & vs;

        if (hs_fall) begin
            k = '0;
        end else if (hcnt_q == HMAX) begin
            k = HMAX;
        end else begin
            k = hcnt_q + 11'd1;
        end
        hsat     = (k == HMAX);
        h_period = hcnt_q + 11'd1;
        hcnt_d   = k;

        lnext = (lcnt_q == LMAX) ? LMAX : lcnt_q + 10'd1;

        // A VS fall early in the line claims the current line as line 0;
        // a late one defers the frame start to the next HS fall.
        fstart = (vs_fall && (k < 11'(VWIN))) || (hs_fall && pend_q);

        // Line count of the frame that just ended. When the frame start does
        // not coincide with an HS fall, the current line was already counted
        // by lcnt_q and is being relabelled as line 0.
        frame_lines = hs_fall ? lnext : lcnt_q;

        if (fstart) begin
            lcnt_d = '0;
        end else if (hs_fall) begin
            lcnt_d = lnext;
        end else begin
            lcnt_d = lcnt_q;
        end

        if (fstart) begin
            pend_d = 1'b0;
        end else if (vs_fall) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        vsw_d = vs_rise ? lcnt_d : vsw_q;

        mis = (hs_fall && (h_period != hper_q)) ||
              (hs_rise && (k != hsw_q)) ||
              (vs_rise && (lcnt_d != vsyw_q)) ||
              (fstart && (frame_lines != vlin_q));
    end

    // -----------------------------------------------------------------------
    // Lock FSM and measurement latches
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hp_got_d = hp_got_q;
        hw_got_d = hw_got_q;
        hper_d   = hper_q;
        hsw_d    = hsw_q;
        vlin_d   = vlin_q;
        vsyw_d   = vsyw_q;
        err_d    = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (!hsat && fstart) begin
                    state_d  = MEASURE;
                    hp_got_d = 1'b0;
                    hw_got_d = 1'b0;
                end
            end
            MEASURE: begin
                if (hsat) begin
                    state_d = SEARCH;
                end else begin
                    if (hs_rise && !hw_got_q) begin
                        hsw_d    = k;
                        hw_got_d = 1'b1;
                    end
                    if (hs_fall && !hp_got_q) begin
                        hper_d   = h_period;
                        hp_got_d = 1'b1;
                    end
                    if (fstart) begin
                        // A frame too short to hold a full line cannot be measured.
                        if (hp_got_q && hw_got_q) begin
                            vlin_d  = frame_lines;
                            vsyw_d  = vsw_q;
                            state_d = VERIFY;
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
            end
            VERIFY: begin
                if (hsat || mis) begin
                    state_d = SEARCH;
                end else if (fstart) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (hsat || mis) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Active window. Computed one bit wider than the operands so that a window
    // running past the measured period/frame length is caught and suppressed.
    // -----------------------------------------------------------------------
    always_comb begin
        h_lo = {1'b0, hsw_q} + 12'(HB);
        h_hi = h_lo + 12'(HC) - 12'd1;
        v_lo = {1'b0, vsyw_q} + 11'(VB);
        v_hi = v_lo + 11'(VC) - 11'd1;

        h_in = ({1'b0, k} >= h_lo) && ({1'b0, k} <= h_hi) && (h_hi < {1'b0, hper_q});
        v_in = ({1'b0, lcnt_d} >= v_lo) && ({1'b0, lcnt_d} <= v_hi) &&
               (v_hi < {1'b0, vlin_q});

        de_d = (state_d == LOCKED) && h_in && v_in;
        x_d  = de_d ? (k[9:0] - h_lo[9:0]) : '0;
        y_d  = ((state_d == LOCKED) && v_in) ? (lcnt_d - v_lo[9:0]) : '0;
    end

    // Idle sync level is high, so the edge detectors start from 1 to avoid a
    // false rising edge on the first sample after reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= SEARCH;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            pend_q   <= 1'b0;
            vsw_q    <= '0;
            hp_got_q <= 1'b0;
            hw_got_q <= 1'b0;
            hper_q   <= '0;
            hsw_q    <= '0;
            vlin_q   <= '0;
            vsyw_q   <= '0;
            de_q     <= 1'b0;
            err_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            hs_q     <= hs;
            vs_q     <= vs;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            pend_q   <= pend_d;
            vsw_q    <= vsw_d;
            hp_got_q <= hp_got_d;
            hw_got_q <= hw_got_d;
            hper_q   <= hper_d;
            hsw_q    <= hsw_d;
            vlin_q   <= vlin_d;
            vsyw_q   <= vsyw_d;
            de_q     <= de_d;
            err_q    <= err_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

`ifdef VGA_DECODE_STATS_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if ((state_q == LOCKED) && fstart) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frameCount = fcnt_q;
`else
    assign frameCount = '0;
`endif

    assign locked  = (state_q == LOCKED);
    assign de      = de_q;
    assign x       = x_q;
    assign y       = y_q;
    assign hPeriod = hper_q;
    assign hSyncW  = hsw_q;
    assign vLines  = vlin_q;
    assign vSyncW  = vsyw_q;
    assign err     = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Small-mode bench: HS 6 / HB 4 / HC 16 / front 4 (30 clocks per line),
// VS 2 / VB 2 / VC 6 / front 2 (12 lines per frame). The stimulus task pushes
// the expected {x,y} of every active pixel into a queue; the monitor pops one
// entry each time de is seen and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int HB   = 4;
    localparam int HC   = 16;
    localparam int VB   = 2;
    localparam int VC   = 6;
    localparam int VWIN = 8;
    localparam int HSW  = 6;
    localparam int HP   = 30;
    localparam int VSW  = 2;
    localparam int VL   = 12;

    logic        clk    = 1'b0;
    logic        reset_ = 1'b0;
    logic        hs     = 1'b1;
    logic        vs     = 1'b1;
    logic        locked, de, err;
    logic [9:0]  x, y, vLines, vSyncW;
    logic [10:0] hPeriod, hSyncW;
    logic [15:0] frameCount;

    int total = 0;
    int bad = 0;
    int pushed = 0;
    int popped = 0;
    int err_pulses = 0;
    logic [19:0] exp_q[$];

    vga_sync_decoder #(
        .HB(HB), .HC(HC), .VB(VB), .VC(VC), .VWIN(VWIN)
    ) dut (
        .clk(clk), .reset_(reset_), .hs(hs), .vs(vs),
        .locked(locked), .de(de), .x(x), .y(y),
        .hPeriod(hPeriod), .hSyncW(hSyncW), .vLines(vLines), .vSyncW(vSyncW),
        .err(err), .frameCount(frameCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_) begin
            if (err) begin
                err_pulses++;
                check("locked_on_err", locked, 0);
                check("de_on_err", de, 0);
            end
            if (de) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d expected no pixel", x, y);
                end else begin : pop_blk
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    check("pix_x", x, e[19:10]);
                    check("pix_y", y, e[9:0]);
                end
            end else begin
                check("x_idle", x, 0);
            end
        end
    end

    // One generated frame. d = VS fall offset in clocks from the line-0 HS fall.
    // With d >= VWIN the decoder's line 0 is generator line 1.
    // long_line (>=0) gets one extra clock; pixels after it are not expected.
    // lk = expected locked just after this frame's start, and pixel expectation.
    task automatic send_frame(input int d, input int nlines, input int long_line,
                              input bit lk, input int exp_vsw);
        int p, pos, dl, vlo, fl, fk;
        vlo = exp_vsw + VB;
        fl  = (d < VWIN) ? 0 : 1;
        fk  = (d < VWIN) ? d + 1 : 1;
        for (int l = 0; l < nlines; l++) begin
            p = (l == long_line) ? HP + 1 : HP;
            for (int k = 0; k < p; k++) begin
                @(posedge clk);
                #1;
                hs  = (k < HSW) ? 1'b0 : 1'b1;
                pos = l * HP + k;
                vs  = (pos >= d && pos < d + VSW * HP) ? 1'b0 : 1'b1;
                dl  = (d < VWIN) ? l : l - 1;
                if (lk && (long_line < 0 || l <= long_line) &&
                    dl >= vlo && dl <= vlo + VC - 1 &&
                    k >= HSW + HB && k < HSW + HB + HC) begin
                    exp_q.push_back({10'(k - HSW - HB), 10'(dl - vlo)});
                    pushed++;
                end
                if (l == fl && k == fk) check("locked_after_fstart", locked, lk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_de", de, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_hPeriod", hPeriod, 0);
        check("rst_hSyncW", hSyncW, 0);
        check("rst_vLines", vLines, 0);
        check("rst_vSyncW", vSyncW, 0);
        check("rst_err", err, 0);
        check("rst_frameCount", frameCount, 0);
        @(posedge clk);
        #1 reset_ = 1'b1;

        // Clean stream, VS aligned with HS: locks at the third frame start
        for (int f = 0; f < 5; f++) send_frame(0, VL, -1, f >= 2, VSW);
        check("hPeriod", hPeriod, HP);
        check("hSyncW", hSyncW, HSW);
        check("vLines", vLines, VL);
        check("vSyncW", vSyncW, VSW);
        check("locked_clean", locked, 1);
        check("err_count_clean", err_pulses, 0);

        // One line lengthened by a clock: err, then relock on the third frame start
        send_frame(0, VL, 5, 1'b1, VSW);
        check("err_count_long_line", err_pulses, 1);
        check("locked_after_long_line", locked, 0);
        send_frame(0, VL, -1, 1'b0, VSW);
        send_frame(0, VL, -1, 1'b0, VSW);
        send_frame(0, VL, -1, 1'b1, VSW);
        check("relocked", locked, 1);

        // HS held high until hcnt saturates
        repeat (2100) begin
            @(posedge clk);
            #1;
            hs = 1'b1;
            vs = 1'b1;
        end
        check("locked_after_sat", locked, 0);
        check("err_count_sat", err_pulses, 2);

        // VS falls 2 clocks after HS fall: that line is line 0
        for (int f = 0; f < 4; f++) send_frame(2, VL, -1, f >= 2, VSW);
        check("vwin_in_hPeriod", hPeriod, HP);
        check("vwin_in_vSyncW", vSyncW, VSW);

        // Reset in the middle of a locked frame: no err, back to SEARCH
        send_frame(2, 3, -1, 1'b1, VSW);
        @(posedge clk);
        #1 reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_hPeriod", hPeriod, 0);
        check("midrst_err", err, 0);
        @(posedge clk);
        #1 reset_ = 1'b1;

        // VS falls 20 clocks after HS fall: the next line is line 0, VS width 1
        for (int f = 0; f < 4; f++) send_frame(20, VL, -1, f >= 2, VSW - 1);
        check("vwin_out_vLines", vLines, VL);
        check("vwin_out_vSyncW", vSyncW, VSW - 1);
        check("vwin_out_hSyncW", hSyncW, HSW);
        check("vwin_out_locked", locked, 1);

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("pixel_count", popped, pushed);
        check("err_count_final", err_pulses, 2);
`ifdef VGA_DECODE_STATS_EN
        check("frameCount", frameCount, 1);
`else
        check("frameCount", frameCount, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
